majority_vote_arbiter: RTL and testbench

MAJORITY_VOTE_ARBITER -- requirements
Module: majority_vote_arbiter

---
 rtl/majority_vote_pkg.sv | 24 ++
 rtl/majority_vote_arbiter_detector.sv | 20 ++
 rtl/majority_vote_arbiter.sv | 139 +++++++++++++
 tb/tb_majority_vote_arbiter.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/majority_vote_pkg.sv
// Shared definitions for the majority-vote arbiter.
//   state_t      : FSM state encoding (IDLE=0, EVAL=1, RESP=2)
//   NREQ_DEFAULT : default number of requesters
//   ONES_CNT_W   : width of the saturating "ones" response counter
//   idw_of()     : requester-ID width for a given requester count
package majority_vote_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int NREQ_DEFAULT = 4;
    localparam int ONES_CNT_W   = 8;

    // clog2 of the requester count, floored at 1 so a port width is never zero.
    function automatic int idw_of(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    localparam int IDW_DEFAULT = idw_of(NREQ_DEFAULT);

endpackage

// File: rtl/majority_vote_arbiter_detector.sv
// PairTripleDetector_GL: gate-level 2-of-3 detector.
//   in0, in1, in2 : the three vote bits
//   y             : 1 when at least two of the inputs are 1
module PairTripleDetector_GL (
    input  logic in0,
    input  logic in1,
    input  logic in2,
    output logic y
);

    logic a01;
    logic a12;
    logic a02;

    and g_a01 (a01, in0, in1);
    and g_a12 (a12, in1, in2);
    and g_a02 (a02, in0, in2);
    or  g_y   (y, a01, a12, a02);

endmodule

// File: rtl/majority_vote_arbiter.sv
// majority_vote_arbiter: NREQ requesters share one 2-of-3 majority evaluator.
// A round-robin grant picks one valid requester in IDLE, its vote is latched,
// evaluated in EVAL and presented in RESP until the consumer takes it.
//   clk       : clock, rising edge
//   rst_n     : asynchronous active-low reset
//   req_val   : per-requester vote valid
//   req_vote  : packed 3-bit votes, requester i at [3i+2:3i]
//   req_rdy   : per-requester accept strobe (one-hot or zero)
//   resp_val  : result valid
//   resp_rdy  : consumer takes the result
//   resp_out  : majority result
//   resp_id   : requester index owning resp_out
//   busy      : FSM not in IDLE
//   ones_cnt  : saturating count of completed responses with resp_out=1
module majority_vote_arbiter
    import majority_vote_pkg::*;
#(
    parameter  int NREQ = NREQ_DEFAULT,
    localparam int IDW  = idw_of(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_val,
    input  logic [3*NREQ-1:0]     req_vote,
    output logic [NREQ-1:0]       req_rdy,
    output logic                  resp_val,
    input  logic                  resp_rdy,
    output logic                  resp_out,
    output logic [IDW-1:0]        resp_id,
    output logic                  busy,
    output logic [ONES_CNT_W-1:0] ones_cnt
);

    state_t                  state_reg;
    logic [IDW-1:0]          ptr_reg;
    logic [IDW-1:0]          id_reg;
    logic [2:0]              vote_reg;
    logic                    res_reg;
    logic [ONES_CNT_W-1:0]   ones_cnt_reg;

    logic [2:0]              votes [NREQ];
    logic [IDW:0]            pick;
    logic                    grant_found;
    logic [IDW-1:0]          grant_idx;
    logic                    grant_ok;
    logic [IDW-1:0]          ptr_next;
    logic                    maj;

    // Unpack the flat vote bus into per-requester 3-bit votes.
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign votes[gi] = req_vote[3*gi +: 3];
        end
    endgenerate

    // Round-robin search starting at ptr; returns {found, index}.
    function automatic logic [IDW:0] rr_pick(input logic [NREQ-1:0] val,
                                             input logic [IDW-1:0]  ptr);
        logic           found;
        logic [IDW-1:0] idx;
        int             j;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            j = int'(ptr) + k;
            if (j >= NREQ) begin
                j = j - NREQ;
            end
            if (!found && val[j]) begin
                found = 1'b1;
                idx   = IDW'(j);
            end
        end
        return {found, idx};
    endfunction

    assign pick        = rr_pick(req_val, ptr_reg);
    assign grant_found = pick[IDW];
    assign grant_idx   = pick[IDW-1:0];
    // rst_n gates the strobe so nothing is offered while reset is held.
    assign grant_ok    = (state_reg == IDLE) && rst_n && grant_found;
    assign ptr_next    = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_rdy
            assign req_rdy[gi] = grant_ok && (grant_idx == IDW'(gi));
        end
    endgenerate

    PairTripleDetector_GL u_detector (
        .in0 (vote_reg[0]),
        .in1 (vote_reg[1]),
        .in2 (vote_reg[2]),
        .y   (maj)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            ptr_reg      <= '0;
            id_reg       <= '0;
            vote_reg     <= '0;
            res_reg      <= 1'b0;
            ones_cnt_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (grant_found) begin
                        vote_reg  <= votes[grant_idx];
                        id_reg    <= grant_idx;
                        ptr_reg   <= ptr_next;
                        state_reg <= EVAL;
                    end
                end
                EVAL: begin
                    res_reg   <= maj;
                    state_reg <= RESP;
                end
                RESP: begin
                    if (resp_rdy) begin
                        state_reg <= IDLE;
                        if (res_reg && (ones_cnt_reg != '1)) begin
                            ones_cnt_reg <= ones_cnt_reg + 1'b1;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // All outputs below come straight from registers or a state decode.
    assign resp_val = (state_reg == RESP);
    assign busy     = (state_reg != IDLE);
    assign resp_out = res_reg;
    assign resp_id  = id_reg;
    assign ones_cnt = ones_cnt_reg;

endmodule

// File: tb/tb_majority_vote_arbiter.sv
// Directed bench for majority_vote_arbiter with a scoreboard queue: the
// stimulus side pushes the expected response at grant time and an
// independent monitor pops and compares when resp_val rises.
module tb_majority_vote_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req_val = 4'b0;
    logic [11:0] req_vote = 12'b0;
    logic [3:0]  req_rdy;
    logic        resp_val;
    logic        resp_rdy = 1'b1;
    logic        resp_out;
    logic [1:0]  resp_id;
    logic        busy;
    logic [7:0]  ones_cnt;

    majority_vote_arbiter #(.NREQ(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_val  (req_val),
        .req_vote (req_vote),
        .req_rdy  (req_rdy),
        .resp_val (resp_val),
        .resp_rdy (resp_rdy),
        .resp_out (resp_out),
        .resp_id  (resp_id),
        .busy     (busy),
        .ones_cnt (ones_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int id;
        int out;
        int cyc;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   exp_ones = 0;
    int   txn_no = 0;
    logic prev_val = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compares each new response against the oldest expectation.
    always @(negedge clk) begin
        #1;
        if (!rst_n) begin
            prev_val = 1'b0;
        end else begin
            if (resp_val && !prev_val) begin
                if (sb.size() == 0) begin
                    chk("unexpected_resp", sb.size(), 1);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("resp_id", resp_id, e.id);
                    chk("resp_out", resp_out, e.out);
                    chk("resp_latency", cyc - e.cyc, 2);
                    txn_no++;
                    $display("txn %0d: id=%0d out=%0d exp_id=%0d exp_out=%0d latency=%0d",
                             txn_no, resp_id, resp_out, e.id, e.out, cyc - e.cyc);
                end
            end
            prev_val = resp_val;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    // Holds reset for a few cycles with all requesters asking; nothing may be offered.
    task automatic do_reset();
        rst_n   = 1'b0;
        req_val = 4'b1111;
        repeat (2) @(negedge clk);
        #2;
        chk("rst_req_rdy", req_rdy, 0);
        chk("rst_resp_val", resp_val, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ones_cnt", ones_cnt, 0);
        req_val  = 4'b0;
        rst_n    = 1'b1;
        exp_ones = 0;
    endtask

    // One transaction: drive, check the grant, push expectation, wait for completion.
    task automatic do_txn(input logic [3:0] val, input logic [11:0] votes,
                          input int exp_id, input int exp_out);
        int         n;
        logic [3:0] onehot;
        req_val  = val;
        req_vote = votes;
        #1;
        n = 0;
        while (req_rdy == 4'b0 && n < 20) begin
            @(negedge clk);
            #2;
            n++;
        end
        onehot = 4'b0001 << exp_id;
        chk("req_rdy_grant", req_rdy, onehot);
        sb.push_back('{exp_id, exp_out, cyc});
        @(posedge clk);
        n = 0;
        do begin
            @(negedge clk);
            #2;
            n++;
        end while (busy && n < 40);
        chk("txn_complete", busy, 0);
        if (exp_out != 0 && exp_ones < 255) exp_ones++;
        chk("ones_cnt", ones_cnt, exp_ones);
    endtask

    initial begin
        logic [7:0]  maj_table;
        logic [11:0] v;
        int          n;

        // Reset and the single-requester example.
        do_reset();
        do_txn(4'b0001, 12'b000_000_000_011, 0, 1);
        chk("ones_after_first", ones_cnt, 1);

        // All four requesting with fixed votes: rotation 0,1,2,3,0.
        do_reset();
        v = {3'b100, 3'b110, 3'b001, 3'b111};
        do_txn(4'b1111, v, 0, 1);
        do_txn(4'b1111, v, 1, 0);
        do_txn(4'b1111, v, 2, 1);
        do_txn(4'b1111, v, 3, 0);
        do_txn(4'b1111, v, 0, 1);
        chk("ones_after_rotation", ones_cnt, 3);

        // Every vote pattern through requester 2.
        maj_table = 8'b1110_1000;
        for (int p = 0; p < 8; p++) begin
            v = {3'b000, 3'(p), 6'b0};
            do_txn(4'b0100, v, 2, int'(maj_table[p]));
        end

        // Consumer stall: result must hold, nothing else granted.
        req_val  = 4'b0100;
        req_vote = {3'b000, 3'b101, 6'b0};
        resp_rdy = 1'b0;
        #1;
        chk("stall_grant", req_rdy, 4'b0100);
        sb.push_back('{2, 1, cyc});
        @(posedge clk);
        n = 0;
        do begin
            @(negedge clk);
            #2;
            n++;
        end while (!resp_val && n < 10);
        chk("stall_resp_seen", resp_val, 1);
        req_val = 4'b1111;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #2;
            chk("stall_resp_val", resp_val, 1);
            chk("stall_resp_out", resp_out, 1);
            chk("stall_resp_id", resp_id, 2);
            chk("stall_req_rdy", req_rdy, 0);
        end
        resp_rdy = 1'b1;
        @(negedge clk);
        #2;
        chk("stall_idle_after", busy, 0);
        chk("stall_resp_val_drop", resp_val, 0);
        req_val = 4'b0;
        exp_ones++;
        chk("stall_ones_cnt", ones_cnt, exp_ones);

        // Reset during EVAL aborts; pointer returns to 0 (ptr is 3 here, so req1 wins).
        req_val  = 4'b0010;
        req_vote = {3'b000, 3'b000, 3'b111, 3'b000};
        #1;
        chk("abort_grant", req_rdy, 4'b0010);
        @(posedge clk);
        @(negedge clk);
        #2;
        chk("abort_in_eval", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("abort_resp_val", resp_val, 0);
        chk("abort_busy", busy, 0);
        chk("abort_ones_cnt", ones_cnt, 0);
        chk("abort_req_rdy", req_rdy, 0);
        exp_ones = 0;
        repeat (3) @(negedge clk);
        #2;
        chk("abort_no_resp", resp_val, 0);
        rst_n = 1'b1;
        do_txn(4'b1100, {3'b000, 3'b011, 3'b000, 3'b000}, 2, 1);

        // Saturation of the ones counter.
        do_reset();
        for (int t = 0; t < 300; t++) begin
            do_txn(4'b0001, 12'b000_000_000_111, 0, 1);
            if (t == 253) chk("ones_before_sat", ones_cnt, 254);
        end
        chk("ones_saturated", ones_cnt, 255);

        req_val = 4'b0;
        repeat (4) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
